// File: rtl/press_pkg.sv
// Shared types and default timings for the push-button press classifier.
package press_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DB     = 3'd1,
    ST_PRESS  = 3'd2,
    ST_LONG   = 3'd3,
    ST_GAP    = 3'd4,
    ST_GDB    = 3'd5,
    ST_SECOND = 3'd6
  } press_state_t;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_DEBOUNCE_P   = 300;
  localparam int DEF_LONG_T       = 5000;
  localparam int DEF_DOUBLE_GAP_T = 400;
  localparam int SYNC_DEPTH       = 2;

  // States in which the debounced level output reads as pressed.
  function automatic logic is_held(press_state_t st);
    return (st == ST_PRESS) || (st == ST_LONG) || (st == ST_SECOND);
  endfunction

endpackage

// File: rtl/press_channel.sv
// One button channel: 2-FF synchroniser, debounce/classify FSM and saturating timer.
// Double-click states (GAP, GDB, SECOND) are compiled in only with PRESS_DOUBLE_CLICK_EN.
//
//   state  | meaning
//   IDLE   | released, waiting for a synchronised press
//   DB     | press seen, waiting for it to stay stable for DEBOUNCE_P cycles
//   PRESS  | accepted press, timing towards long
//   LONG   | press held past LONG_T, waiting for release
//   GAP    | short press released, waiting for a possible repress
//   GDB    | repress seen during the gap, debouncing it
//   SECOND | accepted second press, waiting for release
module press_channel
  import press_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEBOUNCE_P   = DEF_DEBOUNCE_P,
  parameter int LONG_T       = DEF_LONG_T,
  parameter int DOUBLE_GAP_T = DEF_DOUBLE_GAP_T
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pressed,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse
);

  localparam longint CNT_LIMIT = longint'(1) << CNT_W;

  if (CNT_W < 1 || DEBOUNCE_P < 1 || LONG_T < 1 || DOUBLE_GAP_T < 1 ||
      DEBOUNCE_P >= CNT_LIMIT || LONG_T >= CNT_LIMIT || DOUBLE_GAP_T >= CNT_LIMIT) begin : g_param_check
    $error("press_channel: timing parameters must be >= 1 and < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_P - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_T - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [SYNC_DEPTH-1:0] sync;
  logic                  s;
  press_state_t          state, next_state;
  logic [CNT_W-1:0]      cnt;
  logic                  short_n, long_n;

  assign s = sync[SYNC_DEPTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[SYNC_DEPTH-2:0], button};
  end

`ifdef PRESS_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DOUBLE_GAP_T - 1);
  logic double_n;
`endif

  always_comb begin
    next_state = state;
    short_n    = 1'b0;
    long_n     = 1'b0;
`ifdef PRESS_DOUBLE_CLICK_EN
    double_n   = 1'b0;
`endif
    case (state)
      ST_IDLE:  if (s) next_state = ST_DB;
      ST_DB: begin
        if (!s)                 next_state = ST_IDLE;
        else if (cnt == DB_LAST) next_state = ST_PRESS;
      end
      ST_PRESS: begin
        if (!s) begin
`ifdef PRESS_DOUBLE_CLICK_EN
          next_state = ST_GAP;
`else
          next_state = ST_IDLE;
          short_n    = 1'b1;
`endif
        end else if (cnt == LONG_LAST) begin
          next_state = ST_LONG;
        end
      end
      ST_LONG: begin
        if (!s) begin
          next_state = ST_IDLE;
          long_n     = 1'b1;
        end
      end
`ifdef PRESS_DOUBLE_CLICK_EN
      ST_GAP: begin
        if (s) begin
          next_state = ST_GDB;
        end else if (cnt == GAP_LAST) begin
          next_state = ST_IDLE;
          short_n    = 1'b1;
        end
      end
      // A bounce while debouncing the repress ends the gap: report the first press.
      ST_GDB: begin
        if (!s) begin
          next_state = ST_IDLE;
          short_n    = 1'b1;
        end else if (cnt == DB_LAST) begin
          next_state = ST_SECOND;
        end
      end
      ST_SECOND: begin
        if (!s) begin
          next_state = ST_IDLE;
          double_n   = 1'b1;
        end
      end
`endif
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pressed     <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      state       <= next_state;
      if (next_state != state)  cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      pressed     <= is_held(next_state);
      short_pulse <= short_n;
      long_pulse  <= long_n;
    end
  end

`ifdef PRESS_DOUBLE_CLICK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) double_pulse <= 1'b0;
    else      double_pulse <= double_n;
  end
`else
  assign double_pulse = 1'b0;
`endif

endmodule

// File: rtl/press_classifier_multi.sv
// N_CH independent push-button classifiers (short / long / double click).
// Double-click support is enabled by defining PRESS_DOUBLE_CLICK_EN.
module press_classifier_multi
  import press_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEBOUNCE_P   = DEF_DEBOUNCE_P,
  parameter int LONG_T       = DEF_LONG_T,
  parameter int DOUBLE_GAP_T = DEF_DOUBLE_GAP_T
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] push_button,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] short_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] double_pulse
);

  if (N_CH < 1) begin : g_param_check
    $error("press_classifier_multi: N_CH must be >= 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    press_channel #(
      .CNT_W        (CNT_W),
      .DEBOUNCE_P   (DEBOUNCE_P),
      .LONG_T       (LONG_T),
      .DOUBLE_GAP_T (DOUBLE_GAP_T)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .button       (push_button[i]),
      .pressed      (pressed[i]),
      .short_pulse  (short_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .double_pulse (double_pulse[i])
    );
  end

endmodule

// File: tb/tb_press_classifier_multi.sv
// Scoreboard bench for press_classifier_multi: directed presses push expected events
// (pulses and pressed edges, stamped with cycle numbers); a monitor pops and compares.
module tb_press_classifier_multi;

  localparam int N_CH = 2;
  localparam int DBP  = 4;
  localparam int LT   = 20;
  localparam int GT   = 10;
`ifdef PRESS_DOUBLE_CLICK_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  localparam int K_SHORT  = 0;
  localparam int K_LONG   = 1;
  localparam int K_DOUBLE = 2;
  localparam int K_RISE   = 3;
  localparam int K_FALL   = 4;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t exp_q[$];

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] push_button;
  logic [N_CH-1:0] pressed, short_pulse, long_pulse, double_pulse;
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  press_classifier_multi #(
    .N_CH(N_CH), .CNT_W(8), .DEBOUNCE_P(DBP), .LONG_T(LT), .DOUBLE_GAP_T(GT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_button  (push_button),
    .pressed      (pressed),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .double_pulse (double_pulse)
  );

  function automatic int key(ev_t e);
    return e.cyc * 16 + e.ch * 8 + e.kind;
  endfunction

  task automatic expect_ev(input int c, input int ch, input int kind);
    ev_t e;
    int  i;
    e.cyc = c; e.ch = ch; e.kind = kind;
    i = 0;
    while (i < exp_q.size() && key(exp_q[i]) <= key(e)) i++;
    exp_q.insert(i, e);
  endtask

  // Isolated clean press: raw high at cycle p for h cycles, no repress within the gap.
  task automatic expect_single(input int ch, input int p, input int h);
    int r;
    r = p + h;
    expect_ev(p + DBP + 3, ch, K_RISE);
    expect_ev(r + 3, ch, K_FALL);
    if (h - DBP - 1 >= LT) expect_ev(r + 3, ch, K_LONG);
    else                   expect_ev(DC ? r + GT + 3 : r + 3, ch, K_SHORT);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press(input int ch, input int p, input int h);
    wait_until(p);
    push_button[ch] = 1'b1;
    wait_until(p + h);
    push_button[ch] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    logic [4*N_CH-1:0] act;
    act = {pressed, short_pulse, long_pulse, double_pulse};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (act[i*N_CH +: N_CH] !== '0) begin
        bad++;
        $display("FAIL %s output group %0d: got %b, required 0", tag, i, act[i*N_CH +: N_CH]);
      end
    end
  endtask

  // Monitor: every observed event must be the next expected one; stale entries are misses.
  initial begin
    logic [N_CH-1:0] prev;
    logic            hit;
    ev_t             obs;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          for (int k = 0; k < 5; k++) begin
            case (k)
              K_SHORT:  hit = (short_pulse[ch] === 1'b1);
              K_LONG:   hit = (long_pulse[ch] === 1'b1);
              K_DOUBLE: hit = (double_pulse[ch] === 1'b1);
              K_RISE:   hit = (pressed[ch] === 1'b1) && !prev[ch];
              default:  hit = (pressed[ch] !== 1'b1) && prev[ch];
            endcase
            if (hit) begin
              obs.cyc = cyc; obs.ch = ch; obs.kind = k;
              while (exp_q.size() > 0 && key(exp_q[0]) < key(obs)) begin
                total++; bad++;
                $display("FAIL missing event ch%0d kind=%0d: got none by cyc %0d, required at cyc %0d",
                         exp_q[0].ch, exp_q[0].kind, cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
              end
              total++;
              if (exp_q.size() > 0 && key(exp_q[0]) == key(obs)) begin
                void'(exp_q.pop_front());
              end else begin
                bad++;
                if (exp_q.size() > 0)
                  $display("FAIL unexpected event: got ch%0d kind=%0d at cyc %0d, required next ch%0d kind=%0d at cyc %0d",
                           ch, k, cyc, exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc);
                else
                  $display("FAIL unexpected event: got ch%0d kind=%0d at cyc %0d, required none", ch, k, cyc);
              end
            end
          end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          total++; bad++;
          $display("FAIL missing event ch%0d kind=%0d: got none, required at cyc %0d",
                   exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
      for (int ch = 0; ch < N_CH; ch++) prev[ch] = (pressed[ch] === 1'b1);
    end
  end

  initial begin
    rst = 1'b0;
    push_button = '0;
    wait_until(2);
    check_zero("reset_state");
    wait_until(3);
    rst = 1'b1;

    // Glitch shorter than the debounce window: no events at all.
    press(0, 10, 3);

    // Long press held 40 cycles.
    expect_single(0, 30, 40);
    press(0, 30, 40);

    // Boundary: 19 PRESS samples is short, 20 is long.
    expect_single(0, 100, 24);
    press(0, 100, 24);
    expect_single(0, 160, 25);
    press(0, 160, 25);

    // Press 8, gap 5, press 8.
    expect_ev(227, 0, K_RISE);
    if (DC) begin
      expect_ev(231, 0, K_FALL);
      expect_ev(240, 0, K_RISE);
      expect_ev(244, 0, K_DOUBLE);
      expect_ev(244, 0, K_FALL);
    end else begin
      expect_ev(231, 0, K_SHORT);
      expect_ev(231, 0, K_FALL);
      expect_ev(240, 0, K_RISE);
      expect_ev(244, 0, K_SHORT);
      expect_ev(244, 0, K_FALL);
    end
    press(0, 220, 8);
    press(0, 233, 8);

    // Press 8, gap 12, press 8: two separate shorts either way.
    expect_single(0, 280, 8);
    expect_single(0, 300, 8);
    press(0, 280, 8);
    press(0, 300, 8);

    // Channel 1 alone, then both channels together with coinciding events.
    expect_single(1, 340, 10);
    press(1, 340, 10);
    expect_single(0, 380, 12);
    expect_single(1, 380, 12);
    wait_until(380);
    push_button = 2'b11;
    wait_until(392);
    push_button = 2'b00;

    // Reset with ch0 in LONG and ch1 just released (in the gap when enabled).
    expect_ev(437, 0, K_RISE);
    expect_ev(457, 1, K_RISE);
    expect_ev(461, 1, K_FALL);
    if (!DC) expect_ev(461, 1, K_SHORT);
    wait_until(430);
    push_button[0] = 1'b1;
    wait_until(450);
    push_button[1] = 1'b1;
    wait_until(458);
    push_button[1] = 1'b0;
    wait_until(464);
    push_button = 2'b11;
    rst = 1'b0;
    #1;
    check_zero("reset_assert");
    wait_until(466);
    check_zero("reset_hold");
    expect_single(0, 467, 14);
    expect_single(1, 467, 30);
    wait_until(467);
    rst = 1'b1;
    wait_until(481);
    push_button[0] = 1'b0;
    wait_until(497);
    push_button[1] = 1'b0;

    wait_until(530);
    while (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL missing event ch%0d kind=%0d: got none, required at cyc %0d",
               exp_q[0].ch, exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
